serial_subtractor: RTL and testbench

Bit-serial W-bit unsigned subtractor for the Aeolus ALU. It is the inverse operation of the combinational adder: it computes IN1 - IN2 one bit per clock, LSB first, using a single registered borrow. A START/BUSY/DONE handshake lets the ALU sequencer trade latency for area. The result pair {BORROW,OUT} is the (W+1)-bit two's-complement difference {1'b0,IN1} - {1'b0,IN2}.

---
 rtl/serial_subtractor.sv | 167 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor for the Aeolus ALU. Computes IN1 - IN2 one
// bit per clock, LSB first, with a single registered borrow. The pair
// {BORROW, OUT} is the (WIDTH+1)-bit two's-complement difference
// {1'b0,IN1} - {1'b0,IN2}.
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RESET  in   1      asynchronous, active-low reset
//   START  in   1      request, sampled only while idle
//   IN1    in   WIDTH  minuend, captured on the accepting edge
//   IN2    in   WIDTH  subtrahend, captured on the accepting edge
//   OUT    out  WIDTH  registered difference
//   BORROW out  1      final borrow (1 iff IN1 < IN2)
//   ZERO   out  1      1 iff OUT == 0
//   BUSY   out  1      high while bits are being processed
//   DONE   out  1      one-cycle pulse when OUT/BORROW/ZERO update
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    output logic [WIDTH-1:0] OUT,
    output logic             BORROW,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One full-subtractor slice on the current LSBs.
    logic             diff_bit;
    logic             borrow_new;
    logic [WIDTH-1:0] r_shift;
    logic             last_bit;

    assign diff_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    assign borrow_new = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    assign r_shift    = {diff_bit, r_q[WIDTH-1:1]};
    assign last_bit   = (cnt_q == LAST_BIT);

    // -------------------------------------------------------------------------
    // State register (and all datapath/output registers)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_SUB;
            S_SUB:   if (last_bit) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath / output next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d    = IN1;
                    b_d    = IN2;
                    brw_d  = 1'b0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_SUB: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                r_d   = r_shift;
                brw_d = borrow_new;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    // Results are published only here, so they hold steady
                    // for the whole of the next operation.
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    out_d    = r_shift;
                    borrow_d = borrow_new;
                    zero_d   = (r_shift == '0);
                end
            end
            S_FIN: begin
                done_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign OUT    = out_q;
    assign BORROW = borrow_q;
    assign ZERO   = zero_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [W-1:0] IN1;
    logic [W-1:0] IN2;
    logic [W-1:0] OUT;
    logic         BORROW;
    logic         ZERO;
    logic         BUSY;
    logic         DONE;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .IN1    (IN1),
        .IN2    (IN2),
        .OUT    (OUT),
        .BORROW (BORROW),
        .ZERO   (ZERO),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    // Drives one operation and reports what the DUT produced; no comparisons.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] o_out, output logic o_brw,
                          output logic o_zero, output int o_busy,
                          output logic o_timeout, output logic o_done_after);
        int n;
        @(negedge CLK);
        START = 1'b1;
        IN1   = a;
        IN2   = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        IN1   = ~a;        // later input changes must not matter
        IN2   = ~b;
        o_busy = 0;
        n = 0;
        while (!DONE && n < 20) begin
            if (BUSY) o_busy++;
            @(posedge CLK);
            #1;
            n++;
        end
        o_timeout = !DONE;
        o_out  = OUT;
        o_brw  = BORROW;
        o_zero = ZERO;
        @(posedge CLK);
        #1;
        o_done_after = DONE;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        START = 1'b0;
        IN1   = '0;
        IN2   = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({OUT, BORROW, ZERO, BUSY, DONE} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got OUT=%h B=%b Z=%b BUSY=%b DONE=%b, want 0 0 1 0 0",
                     OUT, BORROW, ZERO, BUSY, DONE);
        end
        @(negedge CLK);
        RESET = 1'b1;
        $display("reset: OUT=%h BORROW=%b ZERO=%b", OUT, BORROW, ZERO);
    endtask

    task automatic test_basic();
        logic [W-1:0] o; logic br, z, tmo, da; int bc;
        run_op(4'd9, 4'd3, o, br, z, bc, tmo, da);
        $display("9-3: OUT=%h BORROW=%b ZERO=%b busy=%0d", o, br, z, bc);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout: DONE not seen in 20 cycles"); end
        checks++;
        if ({br, o, z} !== {1'b0, 4'd6, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got B=%b OUT=%h Z=%b, want 0 6 0", br, o, z);
        end
        checks++;
        if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d, want 4", bc); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width: DONE=%b a cycle later, want 0", da); end
    endtask

    task automatic test_borrow();
        logic [W-1:0] o; logic br, z, tmo, da; int bc;
        run_op(4'd3, 4'd9, o, br, z, bc, tmo, da);
        $display("3-9: OUT=%h BORROW=%b ZERO=%b", o, br, z);
        checks++;
        if (tmo || {br, o, z} !== {1'b1, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL borrow_3_9: got B=%b OUT=%h Z=%b tmo=%b, want 1 a 0", br, o, z, tmo);
        end
        run_op(4'd0, 4'd1, o, br, z, bc, tmo, da);
        $display("0-1: OUT=%h BORROW=%b ZERO=%b", o, br, z);
        checks++;
        if (tmo || {br, o, z} !== {1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL wrap_0_1: got B=%b OUT=%h Z=%b tmo=%b, want 1 f 0", br, o, z, tmo);
        end
    endtask

    task automatic test_zero();
        logic [W-1:0] o; logic br, z, tmo, da; int bc;
        run_op(4'd7, 4'd7, o, br, z, bc, tmo, da);
        $display("7-7: OUT=%h BORROW=%b ZERO=%b", o, br, z);
        checks++;
        if (tmo || {br, o, z} !== {1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL zero_7_7: got B=%b OUT=%h Z=%b tmo=%b, want 0 0 1", br, o, z, tmo);
        end
        run_op(4'd0, 4'd0, o, br, z, bc, tmo, da);
        $display("0-0: OUT=%h BORROW=%b ZERO=%b", o, br, z);
        checks++;
        if (tmo || {br, o, z} !== {1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL zero_0_0: got B=%b OUT=%h Z=%b tmo=%b, want 0 0 1", br, o, z, tmo);
        end
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] o; logic br, z, tmo, da; int bc;
        logic [7:0] iv;
        logic [4:0] exp5;
        int start_err;
        start_err = errors;
        for (int i = 0; i < 256; i++) begin
            iv   = 8'(i);
            exp5 = {1'b0, iv[3:0]} - {1'b0, iv[7:4]};
            run_op(iv[3:0], iv[7:4], o, br, z, bc, tmo, da);
            $display("ex %h-%h: OUT=%h BORROW=%b ZERO=%b", iv[3:0], iv[7:4], o, br, z);
            checks++;
            if (tmo || {br, o} !== exp5 || z !== (exp5[3:0] == 4'h0)) begin
                errors++;
                $display("FAIL exhaustive_%0d: got B=%b OUT=%h Z=%b tmo=%b, want %b %h %b",
                         i, br, o, z, tmo, exp5[4], exp5[3:0], exp5[3:0] == 4'h0);
            end
        end
        if (errors == start_err) $display("TEST SUCCESSFUL!");
    endtask

    task automatic test_start_ignored();
        int pulses;
        logic [W-1:0] o;
        logic br;
        pulses = 0;
        o  = 'x;
        br = 1'bx;
        @(negedge CLK);
        START = 1'b1; IN1 = 4'd12; IN2 = 4'd5;
        @(posedge CLK); #1;            // first BUSY cycle
        START = 1'b0;
        @(posedge CLK); #1;            // second BUSY cycle
        START = 1'b1; IN1 = 4'd1; IN2 = 4'd2;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (DONE) begin pulses++; o = OUT; br = BORROW; end
            @(posedge CLK); #1;
        end
        $display("12-5 with stray START: OUT=%h BORROW=%b done_pulses=%0d", o, br, pulses);
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d, want 1", pulses); end
        checks++;
        if ({br, o} !== {1'b0, 4'd7}) begin
            errors++;
            $display("FAIL ignore_result: got B=%b OUT=%h, want 0 7", br, o);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        logic [W-1:0] o; logic br, z, tmo, da; int bc;
        pulses = 0;
        @(negedge CLK);
        START = 1'b1; IN1 = 4'd15; IN2 = 4'd1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #3;            // mid-SUB, between edges
        RESET = 1'b0;
        #1;
        $display("async reset mid-SUB: OUT=%h BORROW=%b ZERO=%b BUSY=%b DONE=%b",
                 OUT, BORROW, ZERO, BUSY, DONE);
        checks++;
        if ({OUT, BORROW, ZERO, BUSY, DONE} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_immediate: got OUT=%h B=%b Z=%b BUSY=%b DONE=%b, want 0 0 1 0 0",
                     OUT, BORROW, ZERO, BUSY, DONE);
        end
        repeat (2) begin
            @(posedge CLK); #1;
            if (DONE) pulses++;
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL async_reset_no_done: got %0d activity cycles, want 0", pulses); end
        run_op(4'd5, 4'd2, o, br, z, bc, tmo, da);
        $display("5-2 after reset: OUT=%h BORROW=%b ZERO=%b", o, br, z);
        checks++;
        if (tmo || {br, o, z} !== {1'b0, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_5_2: got B=%b OUT=%h Z=%b tmo=%b, want 0 3 0", br, o, z, tmo);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_zero();
        test_start_ignored();
        test_async_reset();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
